// File: rtl/myproject_mac_pkg.sv
// Shared types and constants for the pipelined signed multiply/accumulate engine.
package myproject_mac_pkg;

  typedef enum logic {
    MAC_MODE_MUL = 1'b0,
    MAC_MODE_ACC = 1'b1
  } mac_mode_e;

  localparam int unsigned NUM_STAGE_MIN = 1;
  localparam int unsigned NUM_STAGE_MAX = 4;

  // Two's-complement limits for a signed value of the given width (width <= 127).
  function automatic logic signed [127:0] sat_max(input int unsigned width);
    return (128'sd1 <<< (width - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] sat_min(input int unsigned width);
    return -(128'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/myproject_mac_pipe_stage.sv
// One enable-gated pipeline slice carrying {valid, first, last, product}.
module myproject_mac_pipe_stage #(
  parameter int unsigned PROD_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_i,
  input  logic                         valid_i,
  input  logic                         first_i,
  input  logic                         last_i,
  input  logic signed [PROD_WIDTH-1:0] prod_i,
  output logic                         valid_o,
  output logic                         first_o,
  output logic                         last_o,
  output logic signed [PROD_WIDTH-1:0] prod_o
);

  logic                         valid_q;
  logic                         first_q;
  logic                         last_q;
  logic signed [PROD_WIDTH-1:0] prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      prod_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      first_q <= first_i;
      last_q  <= last_i;
      prod_q  <= prod_i;
    end
  end

  assign valid_o = valid_q;
  assign first_o = first_q;
  assign last_o  = last_q;
  assign prod_o  = prod_q;

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined signed multiplier with valid/ready flow control and an optional
// saturating frame accumulator on the output side.
module myproject_mac_pipe
  import myproject_mac_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = 16,
  parameter int unsigned DIN1_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned NUM_STAGE  = 2,
  parameter mac_mode_e   MODE       = MAC_MODE_MUL
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DIN0_WIDTH-1:0] in_a,
  input  logic signed [DIN1_WIDTH-1:0] in_b,
  input  logic                        in_first,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_sat
);

  localparam int unsigned PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  logic                         en;
  logic signed [PROD_WIDTH-1:0] a_ext;
  logic signed [PROD_WIDTH-1:0] b_ext;
  logic [NUM_STAGE:0]           stg_v;
  logic [NUM_STAGE:0]           stg_f;
  logic [NUM_STAGE:0]           stg_l;
  logic signed [PROD_WIDTH-1:0] stg_p [NUM_STAGE+1];

  // One global stall: nothing moves while a presented result is not taken.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  assign a_ext    = PROD_WIDTH'(in_a);
  assign b_ext    = PROD_WIDTH'(in_b);
  assign stg_v[0] = in_valid;
  assign stg_f[0] = in_first;
  assign stg_l[0] = in_last;
  assign stg_p[0] = a_ext * b_ext;

  for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
    myproject_mac_pipe_stage #(
      .PROD_WIDTH(PROD_WIDTH)
    ) u_stage (
      .clk    (ap_clk),
      .rst_n  (ap_rst_n),
      .en_i   (en),
      .valid_i(stg_v[i]),
      .first_i(stg_f[i]),
      .last_i (stg_l[i]),
      .prod_i (stg_p[i]),
      .valid_o(stg_v[i+1]),
      .first_o(stg_f[i+1]),
      .last_o (stg_l[i+1]),
      .prod_o (stg_p[i+1])
    );
  end

  if (MODE == MAC_MODE_ACC) begin : g_acc
    localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'(sat_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH+1)'(sat_min(ACC_WIDTH));

    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH:0]   sum;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        fsat_q, fsat_d;
    logic                        out_valid_q;
    logic signed [ACC_WIDTH-1:0] out_data_q;
    logic                        out_sat_q;

    always_comb begin
      prod_ext = ACC_WIDTH'(stg_p[NUM_STAGE]);
      sum      = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod_ext);
      acc_d    = acc_q;
      fsat_d   = fsat_q;
      if (stg_f[NUM_STAGE]) begin
        acc_d  = prod_ext;
        fsat_d = 1'b0;
      end else if (sum > SAT_HI) begin
        acc_d  = SAT_HI[ACC_WIDTH-1:0];
        fsat_d = 1'b1;
      end else if (sum < SAT_LO) begin
        acc_d  = SAT_LO[ACC_WIDTH-1:0];
        fsat_d = 1'b1;
      end else begin
        acc_d  = sum[ACC_WIDTH-1:0];
      end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        acc_q       <= '0;
        fsat_q      <= 1'b0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_sat_q   <= 1'b0;
      end else if (en) begin
        if (stg_v[NUM_STAGE]) begin
          acc_q  <= acc_d;
          fsat_q <= fsat_d;
        end
        out_valid_q <= stg_v[NUM_STAGE] & stg_l[NUM_STAGE];
        if (stg_v[NUM_STAGE] & stg_l[NUM_STAGE]) begin
          out_data_q <= acc_d;
          out_sat_q  <= fsat_d;
        end
      end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
  end else begin : g_mul
    logic unused_tags;
    assign unused_tags = stg_f[NUM_STAGE] ^ stg_l[NUM_STAGE];
    assign out_valid   = stg_v[NUM_STAGE];
    assign out_data    = ACC_WIDTH'(stg_p[NUM_STAGE]);
    assign out_sat     = 1'b0;
  end

endmodule
